// File: rtl/alu_flag_stage_if.sv
// Handshake bundle between the adder, the flag stage and writeback.
// The slave modport is the flag stage's view; master is the surrounding datapath.
interface alu_flag_stage_if #(
  parameter int N     = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_sum;
  logic             in_cout;
  logic             in_a_msb;
  logic             in_b_msb;
  logic             in_set_flags;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_result;
  logic [3:0]       out_nzcv;
  logic [TAG_W-1:0] out_tag;
  logic             out_set_flags;
  logic [3:0]       cpsr_nzcv;

  modport slave (
    input  in_valid, in_sum, in_cout, in_a_msb, in_b_msb, in_set_flags, in_tag,
    input  flush, out_ready,
    output in_ready, out_valid, out_result, out_nzcv, out_tag, out_set_flags, cpsr_nzcv
  );

  modport master (
    output in_valid, in_sum, in_cout, in_a_msb, in_b_msb, in_set_flags, in_tag,
    output flush, out_ready,
    input  in_ready, out_valid, out_result, out_nzcv, out_tag, out_set_flags, cpsr_nzcv
  );
endinterface

// File: rtl/alu_flag_stage.sv
// Registers the adder sum, derives NZCV, and hands result+flags to writeback through a
// 2-entry skid buffer; also holds the architectural CPSR flags, committed on emit.
//
// state | meaning
// EMPTY | no entry buffered (main and skid invalid)
// ONE   | main holds the entry on out_*, skid empty
// FULL  | main on out_*, skid holds the next entry; in_ready low
module alu_flag_stage #(
  parameter int N     = 32,
  parameter int TAG_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_flag_stage_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  typedef struct packed {
    logic [N-1:0]     result;
    logic [3:0]       nzcv;
    logic [TAG_W-1:0] tag;
    logic             sf;
  } entry_t;

  state_t     state_q, state_d;
  logic       in_ready_q, in_ready_d;
  entry_t     main_q, main_d;
  entry_t     skid_q, skid_d;
  logic [3:0] cpsr_q, cpsr_d;
  entry_t     in_entry;
  logic       accept;
  logic       emit;

  assign accept = bus.in_valid && in_ready_q;
  assign emit   = (state_q != EMPTY) && bus.out_ready;

  always_comb begin
    in_entry.result = bus.in_sum;
    in_entry.nzcv   = {bus.in_sum[N-1],
                       (bus.in_sum == '0),
                       bus.in_cout,
                       (bus.in_a_msb == bus.in_b_msb) && (bus.in_sum[N-1] != bus.in_a_msb)};
    in_entry.tag    = bus.in_tag;
    in_entry.sf     = bus.in_set_flags;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_entry;
        end
      end
      ONE: begin
        if (accept && !emit) begin
          state_d = FULL;
          skid_d  = in_entry;
        end else if (accept && emit) begin
          main_d = in_entry;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // flush kills buffered entries; a same-cycle emit has already been delivered
    if (bus.flush) state_d = EMPTY;
    in_ready_d = (state_d != FULL);
    cpsr_d     = (emit && main_q.sf) ? main_q.nzcv : cpsr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
      cpsr_q     <= 4'b0000;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      cpsr_q     <= cpsr_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = (state_q != EMPTY);
  assign bus.out_result    = main_q.result;
  assign bus.out_nzcv      = main_q.nzcv;
  assign bus.out_tag       = main_q.tag;
  assign bus.out_set_flags = main_q.sf;
  assign bus.cpsr_nzcv     = cpsr_q;

endmodule
